// File: rtl/gate_selftest_ctrl.sv
// Built-in self-test sequencer for the AND/OR/XOR gate datapath: walks a/b through 00,01,10,11,
// waits for the outputs to settle, then counts vectors whose outputs disagree with the ideal gates.
// Optional first-failure capture is enabled by defining GATE_SELFTEST_FIRST_FAIL_EN.
module gate_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  input  logic             y_and,
  input  logic             y_or,
  input  logic             y_xor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_SELFTEST_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [2:0]       first_fail_res
`endif
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [SET_W-1:0]  SETTLE_RELOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST     = LOOP_W'(LOOPS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic [2:0]        exp_res;
  logic [2:0]        obs_res;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;
  logic [1:0]        vec_inc;
  logic              start_accept;
  logic              check_fire;

  assign exp_res  = {a_q & b_q, a_q | b_q, a_q ^ b_q};
  assign obs_res  = {y_and, y_or, y_xor};
  assign mismatch = (obs_res != exp_res);
  assign vec_inc  = vec_q + 2'd1;

  // One increment per failing vector, held at all-ones once the counter is full.
  assign err_next = (mismatch && !(&err_q)) ? err_q + 1'b1 : err_q;

  assign start_accept = (state_q == ST_IDLE) && start;
  assign check_fire   = (state_q == ST_CHECK) && !abort;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    loop_d   = loop_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d  = ST_SETTLE;
          vec_d    = 2'd0;
          loop_d   = '0;
          settle_d = SETTLE_RELOAD;
          err_d    = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_SETTLE, ST_CHECK: begin
        // Abort takes priority over any start and over the compare of this cycle.
        if (abort) begin
          state_d = ST_IDLE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (state_q == ST_SETTLE) begin
          if (settle_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end else begin
          err_d = err_next;
          if (vec_q != 2'd3) begin
            state_d  = ST_SETTLE;
            vec_d    = vec_inc;
            a_d      = vec_inc[1];
            b_d      = vec_inc[0];
            settle_d = SETTLE_RELOAD;
          end else if (loop_q != LOOP_LAST) begin
            state_d  = ST_SETTLE;
            vec_d    = 2'd0;
            loop_d   = loop_q + 1'b1;
            a_d      = 1'b0;
            b_d      = 1'b0;
            settle_d = SETTLE_RELOAD;
          end else begin
            state_d = ST_IDLE;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= 2'd0;
      loop_q   <= '0;
      settle_q <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      loop_q   <= loop_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef GATE_SELFTEST_FIRST_FAIL_EN
  logic       ff_valid_q, ff_valid_d;
  logic [1:0] ff_vec_q, ff_vec_d;
  logic [2:0] ff_res_q, ff_res_d;

  // Only the first failing vector of a run is captured; later failures leave it alone.
  always_comb begin
    ff_valid_d = ff_valid_q;
    ff_vec_d   = ff_vec_q;
    ff_res_d   = ff_res_q;
    if (start_accept) begin
      ff_valid_d = 1'b0;
      ff_vec_d   = 2'd0;
      ff_res_d   = 3'd0;
    end else if (check_fire && mismatch && !ff_valid_q) begin
      ff_valid_d = 1'b1;
      ff_vec_d   = vec_q;
      ff_res_d   = obs_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_valid_q <= 1'b0;
      ff_vec_q   <= 2'd0;
      ff_res_q   <= 3'd0;
    end else begin
      ff_valid_q <= ff_valid_d;
      ff_vec_q   <= ff_vec_d;
      ff_res_q   <= ff_res_d;
    end
  end

  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_res   = ff_res_q;
`else
  logic unused_ok;
  assign unused_ok = start_accept ^ check_fire;
`endif

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Self-checking bench for gate_selftest_ctrl: three instances (LOOPS 1/3/2, ERR_W 8/8/2) against a
// behavioural gate datapath with injectable faults; a scoreboard holds the expected outcome of each run.
module tb_gate_selftest_ctrl;

  localparam int SETTLE = 2;
  localparam int PERIOD = SETTLE + 1;
  localparam int BUDGET = 500;

  // Fault modes for the modelled datapath.
  localparam int F_NONE     = 0;
  localparam int F_XOR_SA0  = 1;
  localparam int F_AND_INV  = 2;
  localparam int F_OR_SA1   = 3;

  typedef struct {
    int         idx;
    logic [7:0] err;
    logic       pass;
    int         busy_len;
    logic       done;
    logic       ff_valid;
    logic [1:0] ff_vec;
    logic [2:0] ff_res;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] abort;
  logic [2:0] a_w, b_w, busy_w, done_w, pass_w;
  logic [2:0] y_and, y_or, y_xor;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  int         fault [3];
  exp_t       sb [$];
  int         n_checks = 0;
  int         n_pass   = 0;

`ifdef GATE_SELFTEST_FIRST_FAIL_EN
  logic [2:0]      ff_valid;
  logic [2:0][1:0] ff_vec;
  logic [2:0][2:0] ff_res;
`endif

  always #5 clk = ~clk;

  function automatic logic [2:0] gateOut(input logic ia, input logic ib, input int fm);
    logic [2:0] r;
    r = {ia & ib, ia | ib, ia ^ ib};
    if (fm == F_XOR_SA0) r[0] = 1'b0;
    if (fm == F_AND_INV) r[2] = ~r[2];
    if (fm == F_OR_SA1)  r[1] = 1'b1;
    return r;
  endfunction

  always_comb begin
    y_and = '0;
    y_or  = '0;
    y_xor = '0;
    for (int i = 0; i < 3; i++) begin
      {y_and[i], y_or[i], y_xor[i]} = gateOut(a_w[i], b_w[i], fault[i]);
    end
  end

  gate_selftest_ctrl #(.SETTLE_CYCLES(SETTLE), .LOOPS(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .a(a_w[0]), .b(b_w[0]), .y_and(y_and[0]), .y_or(y_or[0]), .y_xor(y_xor[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err0)
`ifdef GATE_SELFTEST_FIRST_FAIL_EN
    , .first_fail_valid(ff_valid[0]), .first_fail_vec(ff_vec[0]), .first_fail_res(ff_res[0])
`endif
  );

  gate_selftest_ctrl #(.SETTLE_CYCLES(SETTLE), .LOOPS(3), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .a(a_w[1]), .b(b_w[1]), .y_and(y_and[1]), .y_or(y_or[1]), .y_xor(y_xor[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err1)
`ifdef GATE_SELFTEST_FIRST_FAIL_EN
    , .first_fail_valid(ff_valid[1]), .first_fail_vec(ff_vec[1]), .first_fail_res(ff_res[1])
`endif
  );

  gate_selftest_ctrl #(.SETTLE_CYCLES(SETTLE), .LOOPS(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
    .a(a_w[2]), .b(b_w[2]), .y_and(y_and[2]), .y_or(y_or[2]), .y_xor(y_xor[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err2)
`ifdef GATE_SELFTEST_FIRST_FAIL_EN
    , .first_fail_valid(ff_valid[2]), .first_fail_vec(ff_vec[2]), .first_fail_res(ff_res[2])
`endif
  );

  function automatic logic [7:0] errOf(input int idx);
    if (idx == 0) return err0;
    if (idx == 1) return err1;
    return {6'b0, err2};
  endfunction

  function automatic int loopsOf(input int idx);
    return (idx == 1) ? 3 : ((idx == 2) ? 2 : 1);
  endfunction

  function automatic int errWidthOf(input int idx);
    return (idx == 2) ? 2 : 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Builds the expected outcome of a run from the datapath model and queues it, then pulses start.
  task automatic applyStimulus(input int idx, input int fm, input int abort_at, input bit with_abort);
    exp_t       e;
    int         lp;
    int         sat;
    int         errc;
    logic [1:0] v;
    logic [2:0] obs;
    lp   = loopsOf(idx);
    sat  = (1 << errWidthOf(idx)) - 1;
    errc = 0;
    e.idx      = idx;
    e.ff_valid = 1'b0;
    e.ff_vec   = 2'd0;
    e.ff_res   = 3'd0;
    for (int j = 0; j < 4 * lp; j++) begin
      if (abort_at > 0 && PERIOD * (j + 1) >= abort_at) break;
      v   = j[1:0];
      obs = gateOut(v[1], v[0], fm);
      if (obs != gateOut(v[1], v[0], F_NONE)) begin
        if (errc < sat) errc++;
        if (!e.ff_valid) begin
          e.ff_valid = 1'b1;
          e.ff_vec   = v;
          e.ff_res   = obs;
        end
      end
    end
    e.err      = 8'(errc);
    e.done     = (abort_at <= 0);
    e.pass     = e.done && (errc == 0);
    e.busy_len = (abort_at > 0) ? abort_at : 4 * lp * PERIOD;
    sb.push_back(e);

    fault[idx] = fm;
    @(negedge clk);
    start[idx] = 1'b1;
    abort[idx] = with_abort;
    @(negedge clk);
    start[idx] = 1'b0;
    abort[idx] = 1'b0;
  endtask

  // Follows one run cycle by cycle, then pops the scoreboard when busy falls.
  task automatic runTest(input string name, input int idx, input int fm, input int restart_at,
                         input int abort_at, input bit with_abort);
    exp_t       e;
    int         n;
    logic [1:0] v;
    applyStimulus(idx, fm, abort_at, with_abort);
    n = 0;
    while (busy_w[idx] && n < BUDGET) begin
      n++;
      v = 2'(((n - 1) / PERIOD) % 4);
      checkOutput({name, ".ab_seq"}, {30'b0, a_w[idx], b_w[idx]}, {30'b0, v});
      start[idx] = (n == restart_at);
      abort[idx] = (n == abort_at);
      @(negedge clk);
    end
    start[idx] = 1'b0;
    abort[idx] = 1'b0;
    checkOutput({name, ".no_timeout"}, 32'(n < BUDGET), 32'd1);
    e = sb.pop_front();
    checkOutput({name, ".sb_idx"},   32'(idx),          32'(e.idx));
    checkOutput({name, ".busy_len"}, 32'(n),            32'(e.busy_len));
    checkOutput({name, ".done"},     {31'b0, done_w[idx]}, {31'b0, e.done});
    checkOutput({name, ".pass"},     {31'b0, pass_w[idx]}, {31'b0, e.pass});
    checkOutput({name, ".err"},      {24'b0, errOf(idx)},  {24'b0, e.err});
    checkOutput({name, ".ab_idle"},  {30'b0, a_w[idx], b_w[idx]}, 32'd0);
`ifdef GATE_SELFTEST_FIRST_FAIL_EN
    checkOutput({name, ".ff_valid"}, {31'b0, ff_valid[idx]}, {31'b0, e.ff_valid});
    checkOutput({name, ".ff_vec"},   {30'b0, ff_vec[idx]},   {30'b0, e.ff_vec});
    checkOutput({name, ".ff_res"},   {29'b0, ff_res[idx]},   {29'b0, e.ff_res});
`endif
    @(negedge clk);
    checkOutput({name, ".done_once"}, {31'b0, done_w[idx]}, 32'd0);
    checkOutput({name, ".pass_hold"}, {31'b0, pass_w[idx]}, {31'b0, e.pass});
    checkOutput({name, ".err_hold"},  {24'b0, errOf(idx)},  {24'b0, e.err});
  endtask

  task automatic checkResetState(input string name, input int idx);
    checkOutput({name, ".busy"}, {31'b0, busy_w[idx]}, 32'd0);
    checkOutput({name, ".done"}, {31'b0, done_w[idx]}, 32'd0);
    checkOutput({name, ".pass"}, {31'b0, pass_w[idx]}, 32'd0);
    checkOutput({name, ".ab"},   {30'b0, a_w[idx], b_w[idx]}, 32'd0);
    checkOutput({name, ".err"},  {24'b0, errOf(idx)}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    abort = '0;
    for (int i = 0; i < 3; i++) fault[i] = F_NONE;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset0", 0);
    checkResetState("reset1", 1);
    checkResetState("reset2", 2);

    runTest("clean", 0, F_NONE, -1, -1, 1'b0);

    // Abort while idle must leave the previous result intact.
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    @(negedge clk);
    checkOutput("idle_abort.busy", {31'b0, busy_w[0]}, 32'd0);
    checkOutput("idle_abort.pass", {31'b0, pass_w[0]}, 32'd1);

    runTest("xor_sa0_x3",   1, F_XOR_SA0, -1, -1, 1'b0);
    runTest("and_inv_sat",  2, F_AND_INV, -1, -1, 1'b0);
    runTest("restart_ign",  0, F_NONE,     5, -1, 1'b0);
    runTest("abort_c7",     0, F_OR_SA1,  -1,  7, 1'b0);
    runTest("busy_st_ab",   0, F_OR_SA1,   4,  4, 1'b0);
    runTest("idle_st_ab",   0, F_NONE,    -1, -1, 1'b1);

    // Reset in the middle of a run, then a fresh run on a clean datapath.
    fault[0] = F_NONE;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrun.busy_before", {31'b0, busy_w[0]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("midrun_rst", 0);
    @(negedge clk);
    checkOutput("midrun.no_done", {31'b0, done_w[0]}, 32'd0);
    runTest("after_rst", 0, F_NONE, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
